// File: rtl/pipe_tnew_tracker.sv
// Tracks destination register, Tnew, PC and valid bit for the ID_EX, EX_MEM
// and MEM_WB stages so the hazard unit can tell when a result is forwardable.
module pipe_tnew_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID_Instr,
  input  logic [31:0] IF_ID_PC,
  input  logic [4:0]  ID_WAddr,
  input  logic        Install,
  input  logic        Flush,
  output logic [4:0]  ID_EX_WAddr,
  output logic [4:0]  EX_MEM_WAddr,
  output logic [4:0]  MEM_WB_WAddr,
  output logic [3:0]  ID_EX_Tnew,
  output logic [3:0]  EX_MEM_Tnew,
  output logic [3:0]  MEM_WB_Tnew,
  output logic [31:0] ID_EX_PC,
  output logic [31:0] EX_MEM_PC,
  output logic [31:0] MEM_WB_PC,
  output logic        ID_EX_Valid,
  output logic        EX_MEM_Valid,
  output logic        MEM_WB_Valid
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] id_tnew;
  logic       bubble;
  logic       unused_instr_bits;

  assign opcode            = IF_ID_Instr[31:26];
  assign funct             = IF_ID_Instr[5:0];
  assign unused_instr_bits = ^IF_ID_Instr[25:6];
  assign bubble            = Install | Flush;

  // Tnew = cycles after entering ID_EX until the value exists in the pipeline.
  // Jumps, branches, stores and mult/div all decode to 0.
  always_comb begin
    id_tnew = 4'd0;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: id_tnew = 4'd2;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:    id_tnew = 4'd1;
      OP_JAL:                              id_tnew = 4'd0;
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:                 id_tnew = 4'd1;
          default:                         id_tnew = 4'd0;
        endcase
      end
      default:                             id_tnew = 4'd0;
    endcase
    if (ID_WAddr == 5'd0) id_tnew = 4'd0;
  end

  function automatic logic [3:0] tnew_step(input logic [3:0] t);
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

  // ID_EX takes a bubble on stall or flush; there is no hold path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_EX_WAddr <= 5'd0;
      ID_EX_Tnew  <= 4'd0;
      ID_EX_PC    <= 32'd0;
      ID_EX_Valid <= 1'b0;
    end else if (bubble) begin
      ID_EX_WAddr <= 5'd0;
      ID_EX_Tnew  <= 4'd0;
      ID_EX_PC    <= 32'd0;
      ID_EX_Valid <= 1'b0;
    end else begin
      ID_EX_WAddr <= ID_WAddr;
      ID_EX_Tnew  <= id_tnew;
      ID_EX_PC    <= IF_ID_PC;
      ID_EX_Valid <= 1'b1;
    end
  end

  // Downstream stages drain unconditionally every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EX_MEM_WAddr <= 5'd0;
      EX_MEM_Tnew  <= 4'd0;
      EX_MEM_PC    <= 32'd0;
      EX_MEM_Valid <= 1'b0;
      MEM_WB_WAddr <= 5'd0;
      MEM_WB_Tnew  <= 4'd0;
      MEM_WB_PC    <= 32'd0;
      MEM_WB_Valid <= 1'b0;
    end else begin
      EX_MEM_WAddr <= ID_EX_WAddr;
      EX_MEM_Tnew  <= tnew_step(ID_EX_Tnew);
      EX_MEM_PC    <= ID_EX_PC;
      EX_MEM_Valid <= ID_EX_Valid;
      MEM_WB_WAddr <= EX_MEM_WAddr;
      MEM_WB_Tnew  <= tnew_step(EX_MEM_Tnew);
      MEM_WB_PC    <= EX_MEM_PC;
      MEM_WB_Valid <= EX_MEM_Valid;
    end
  end

endmodule
